// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths and elaboration checks for the pipeline stage register
package pipe_pkg;
  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 16;
  localparam int OCC_W = 2;
  function automatic bit skid_ok(input int skid);
    return skid == 0 || skid == 1;
  endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one pipeline entry (valid, data, ctrl); ctrl is zeroed and gated whenever the entry is invalid
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_in,
  input  logic [CTRL_W-1:0] c_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  always_comb begin
    valid_d = load ? 1'b1 : (clr ? 1'b0 : valid_q);
    data_d  = load ? d_in : data_q;
    ctrl_d  = load ? c_in : (clr ? '0 : ctrl_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = valid_q ? ctrl_q : '0;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and an optional skid entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);
  if (!skid_ok(SKID) || DATA_W < 1) begin : g_bad_param
    $error("pipe_stage_reg: SKID must be 0 or 1 and DATA_W >= 1");
  end
  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data, m_din;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_cin;
  logic              in_xfer, m_take_s, m_load, m_clr, s_load, s_clr;
  always_comb begin
    in_ready = (SKID == 1) ? !s_valid : (out_ready || !m_valid);
    in_xfer  = in_valid && in_ready && !flush;
    m_take_s = s_valid && out_ready && !flush;
    m_load   = m_take_s || (in_xfer && (!m_valid || out_ready));
    m_clr    = flush || (m_valid && out_ready);
    s_load   = in_xfer && m_valid && !out_ready;
    s_clr    = flush || m_take_s;
    m_din    = s_valid ? s_data : in_data;
    m_cin    = s_valid ? s_ctrl : in_ctrl;
  end
  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m (
    .clk(clk), .rst_n(rst), .load(m_load), .clr(m_clr), .d_in(m_din), .c_in(m_cin),
    .valid(m_valid), .data(m_data), .ctrl(m_ctrl)
  );
  if (SKID == 1) begin : g_skid
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s (
      .clk(clk), .rst_n(rst), .load(s_load), .clr(s_clr), .d_in(in_data), .c_in(in_ctrl),
      .valid(s_valid), .data(s_data), .ctrl(s_ctrl)
    );
  end else begin : g_noskid
    assign s_valid = 1'b0;
    assign s_data  = '0;
    assign s_ctrl  = '0;
  end
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign occupancy = OCC_W'(m_valid) + OCC_W'(s_valid);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks both SKID modes against a queue model of held bundles
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] flush = '0, in_valid = '0, out_ready = '0, in_ready, out_valid;
  logic [95:0] in_data [2];
  logic [15:0] in_ctrl [2];
  logic [95:0] out_data [2];
  logic [15:0] out_ctrl [2];
  logic [1:0]  occ [2];
  int n_tests = 0, n_fail = 0;
  logic [111:0] mem [2][2];
  int cnt [2], tx_seq [2], rx_seq [2];
  bit acc [2];
  bit rnd_phase = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .SKID(g)) u_dut (
      .clk(clk), .rst(rst), .flush(flush[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]), .in_ctrl(in_ctrl[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]), .out_ctrl(out_ctrl[g]),
      .occupancy(occ[g])
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare every output against the model, then advance the model across one clock edge.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      bit ir, ox, ix;
      ir = (k == 1) ? (cnt[k] < 2) : (out_ready[k] || cnt[k] == 0);
      chk($sformatf("out_valid[%0d]", k), 128'(out_valid[k]), 128'(cnt[k] > 0));
      chk($sformatf("in_ready[%0d]", k), 128'(in_ready[k]), 128'(ir));
      chk($sformatf("occupancy[%0d]", k), 128'(occ[k]), 128'(cnt[k]));
      chk($sformatf("out_ctrl[%0d]", k), 128'(out_ctrl[k]), cnt[k] > 0 ? 128'(mem[k][0][111:96]) : 128'(0));
      if (cnt[k] > 0) chk($sformatf("out_data[%0d]", k), 128'(out_data[k]), 128'(mem[k][0][95:0]));
      ox = cnt[k] > 0 && out_ready[k];
      ix = in_valid[k] && ir && !flush[k];
      if (ox && rnd_phase) begin
        chk($sformatf("order[%0d]", k), 128'(out_data[k]), 128'(rx_seq[k] + 1));
        rx_seq[k]++;
      end
      acc[k] = ix;
      if (flush[k]) cnt[k] = 0;
      else begin
        if (ox) begin
          mem[k][0] = mem[k][1];
          cnt[k]--;
        end
        if (ix) begin
          mem[k][cnt[k]] = {in_ctrl[k], in_data[k]};
          cnt[k]++;
          tx_seq[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit r, input bit f, input logic [95:0] d, input logic [15:0] c);
    in_valid = {v, v}; out_ready = {r, r}; flush = {f, f};
    in_data[0] = d; in_data[1] = d; in_ctrl[0] = c; in_ctrl[1] = c;
  endtask

  task automatic drain();
    drive(0, 1, 0, '0, '0);
    repeat (3) step();
  endtask

  initial begin
    int cyc;
    cnt = '{0, 0}; tx_seq = '{0, 0}; rx_seq = '{0, 0}; acc = '{0, 0};
    drive(0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset out_valid", 128'(out_valid[k]), 128'(0));
      chk("reset out_data", 128'(out_data[k]), 128'(0));
      chk("reset out_ctrl", 128'(out_ctrl[k]), 128'(0));
      chk("reset occupancy", 128'(occ[k]), 128'(0));
      chk("reset in_ready", 128'(in_ready[k]), 128'(1));
    end
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
    // streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, 96'(i), 16'(i));
      step();
      for (int k = 0; k < 2; k++) begin
        chk("stream data", 128'(out_data[k]), 128'(i));
        chk("stream valid", 128'(out_valid[k]), 128'(1));
        chk("stream in_ready", 128'(in_ready[k]), 128'(1));
      end
    end
    drain();
    // stall fills M then S; third bundle waits upstream
    drive(1, 0, 0, 96'h10, 16'h1); step();
    drive(1, 0, 0, 96'h11, 16'h2); step();
    chk("stall occ", 128'(occ[1]), 128'(2));
    chk("stall in_ready", 128'(in_ready[1]), 128'(0));
    chk("stall head", 128'(out_data[1]), 128'(96'h10));
    drive(1, 0, 0, 96'h12, 16'h3); step();
    out_ready = 2'b11; step();
    chk("release 1", 128'(out_data[1]), 128'(96'h11));
    chk("release occ", 128'(occ[1]), 128'(1));
    step();
    chk("release 2", 128'(out_data[1]), 128'(96'h12));
    drain();
    // flush with two held entries and a concurrent input
    drive(1, 0, 0, 96'h21, 16'hFFFF); step();
    drive(1, 0, 0, 96'h22, 16'hFFFF); step();
    chk("pre-flush ctrl", 128'(out_ctrl[1]), 128'(16'hFFFF));
    drive(1, 0, 1, 96'h55, 16'hFFFF); step();
    chk("flush valid", 128'(out_valid[1]), 128'(0));
    chk("flush ctrl", 128'(out_ctrl[1]), 128'(0));
    chk("flush occ", 128'(occ[1]), 128'(0));
    drive(0, 1, 0, '0, '0); step(); step();
    chk("flush drop", 128'(out_valid[1]), 128'(0));
    // SKID=0 bubble
    drive(1, 1, 0, 96'h77, 16'h1234); step();
    drive(0, 0, 0, '0, '0);
    #1 chk("bubble in_ready", 128'(in_ready[0]), 128'(0));
    step();
    out_ready = 2'b11; step();
    chk("bubble valid", 128'(out_valid[0]), 128'(0));
    chk("bubble ctrl", 128'(out_ctrl[0]), 128'(0));
    // asynchronous reset mid-cycle with M and S full
    drive(1, 0, 0, 96'hA1, 16'hA1); step();
    drive(1, 0, 0, 96'hA2, 16'hA2); step();
    drive(0, 0, 0, '0, '0);
    chk("prereset occ", 128'(occ[1]), 128'(2));
    #2 rst = 1'b0;
    #1;
    chk("async out_valid", 128'(out_valid[1]), 128'(0));
    chk("async out_ctrl", 128'(out_ctrl[1]), 128'(0));
    chk("async occ", 128'(occ[1]), 128'(0));
    chk("async in_ready", 128'(in_ready[1]), 128'(1));
    cnt = '{0, 0};
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    // randomised backpressure, 1000 bundles per instance
    tx_seq = '{0, 0}; rx_seq = '{0, 0}; acc = '{0, 0};
    rnd_phase = 1;
    drive(0, 0, 0, '0, '0);
    cyc = 0;
    while ((rx_seq[0] < 1000 || rx_seq[1] < 1000) && cyc < 20000) begin
      for (int k = 0; k < 2; k++) begin
        if (!(in_valid[k] && !acc[k])) begin
          in_valid[k] = tx_seq[k] < 1000 && $urandom_range(0, 3) != 0;
          in_data[k]  = 96'(tx_seq[k] + 1);
          in_ctrl[k]  = 16'((tx_seq[k] + 1) * 7);
        end
        out_ready[k] = $urandom_range(0, 2) != 0;
      end
      step();
      cyc++;
    end
    chk("delivered[0]", 128'(rx_seq[0]), 128'(1000));
    chk("delivered[1]", 128'(rx_seq[1]), 128'(1000));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
